// File: rtl/dcache_snoop_responder_pkg.sv
// Shared types and constants for the L1 dcache MSI snoop responder.
//   msi_t          : per-frame coherence state encoding
//   snoop_state_t  : snoop FSM states
//   msi_sanitize() : maps a raw 2-bit state onto a legal msi_t
package dcache_snoop_responder_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORD_W = 32;
  // Byte offset of a 2-word block; the frame index starts right above it.
  localparam int unsigned BLKOFF = 3;

  typedef enum logic [1:0] {
    MSI_I = 2'b00,
    MSI_S = 2'b01,
    MSI_M = 2'b10
  } msi_t;

  typedef enum logic [2:0] {
    SN_IDLE   = 3'd0,
    SN_LOOKUP = 3'd1,
    SN_WB0    = 3'd2,
    SN_WB1    = 3'd3,
    SN_UPDATE = 3'd4,
    SN_HOLD   = 3'd5
  } snoop_state_t;

  // The unused encoding 2'b11 is stored as invalid.
  function automatic msi_t msi_sanitize(input logic [1:0] raw);
    case (raw)
      2'b01:   return MSI_S;
      2'b10:   return MSI_M;
      default: return MSI_I;
    endcase
  endfunction

endpackage

// File: rtl/dcache_snoop_responder_if.sv
// Snoop and writeback bus between the bus controller and one L1 dcache.
//   master : bus controller side (drives ccwait/ccinv/ccsnoopaddr/dwait)
//   slave  : cache side (drives ccwrite/cctrans/dWEN/daddr/dstore)
interface dcache_snoop_responder_if;
  import dcache_snoop_responder_pkg::*;

  logic              ccwait;
  logic              ccinv;
  logic [ADDR_W-1:0] ccsnoopaddr;
  logic              ccwrite;
  logic              cctrans;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;

  modport master (
    output ccwait, ccinv, ccsnoopaddr, dwait,
    input  ccwrite, cctrans, dWEN, daddr, dstore
  );

  modport slave (
    input  ccwait, ccinv, ccsnoopaddr, dwait,
    output ccwrite, cctrans, dWEN, daddr, dstore
  );

endinterface

// File: rtl/dcache_snoop_responder_snoop_state_array.sv
// Per-frame tag + MSI state storage for a direct-mapped dcache.
//   CLK/RST            : clock, synchronous active-high clear to I / tag 0
//   fsm_we/idx/state   : snoop FSM state-only write (wins over local write)
//   loc_we/idx/tag/st  : local controller tag+state write
//   snp_idx -> snp_*   : combinational read for the snoop lookup
//   lk_idx  -> lk_*    : combinational read for the local controller
module snoop_state_array
  import dcache_snoop_responder_pkg::*;
#(
  parameter  int unsigned SETS = 16,
  localparam int unsigned IDXW = $clog2(SETS),
  localparam int unsigned TAGW = ADDR_W - BLKOFF - IDXW
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            fsm_we,
  input  logic [IDXW-1:0] fsm_idx,
  input  msi_t            fsm_state,
  input  logic            loc_we,
  input  logic [IDXW-1:0] loc_idx,
  input  logic [TAGW-1:0] loc_tag,
  input  logic [1:0]      loc_state,
  input  logic [IDXW-1:0] snp_idx,
  output logic [TAGW-1:0] snp_tag,
  output msi_t            snp_state,
  input  logic [IDXW-1:0] lk_idx,
  output logic [TAGW-1:0] lk_tag,
  output msi_t            lk_state
);

  logic [TAGW-1:0] tags   [SETS];
  msi_t            states [SETS];

  // Single write port; a snoop downgrade keeps the stored tag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tags   <= '{default: '0};
      states <= '{default: MSI_I};
    end else if (fsm_we) begin
      states[fsm_idx] <= fsm_state;
    end else if (loc_we) begin
      tags[loc_idx]   <= loc_tag;
      states[loc_idx] <= msi_sanitize(loc_state);
    end
  end

  assign snp_tag   = tags[snp_idx];
  assign snp_state = states[snp_idx];
  assign lk_tag    = tags[lk_idx];
  assign lk_state  = states[lk_idx];

endmodule

// File: rtl/dcache_snoop_responder.sv
// Cache-side MSI snoop responder: answers bus snoops, writes back Modified
// blocks (2 words), downgrades/invalidates frames, and applies local updates.
//   CLK/RST          : clock, synchronous active-high reset
//   bus (slave)      : ccwait/ccinv/ccsnoopaddr in, ccwrite/cctrans out,
//                      dWEN/daddr/dstore out with dwait back-pressure
//   arr_ridx/roff    : data array read address; arr_rdata comes back comb.
//   loc_*            : local frame write; ignored while loc_busy
//   lk_idx/tag/state : live combinational frame lookup
module dcache_snoop_responder
  import dcache_snoop_responder_pkg::*;
#(
  parameter  int unsigned SETS = 16,
  localparam int unsigned IDXW = $clog2(SETS),
  localparam int unsigned TAGW = ADDR_W - BLKOFF - IDXW
) (
  input  logic                  CLK,
  input  logic                  RST,
  dcache_snoop_responder_if.slave bus,
  output logic [IDXW-1:0]       arr_ridx,
  output logic                  arr_roff,
  input  logic [WORD_W-1:0]     arr_rdata,
  input  logic                  loc_set,
  input  logic [IDXW-1:0]       loc_idx,
  input  logic [TAGW-1:0]       loc_tag,
  input  logic [1:0]            loc_state,
  output logic                  loc_busy,
  input  logic [IDXW-1:0]       lk_idx,
  output logic [TAGW-1:0]       lk_tag,
  output logic [1:0]            lk_state
);

  snoop_state_t state, state_next;

  // Snoop context captured when ccwait is first seen in IDLE.
  logic [IDXW-1:0] snp_idx;
  logic [TAGW-1:0] snp_tag;
  logic            snp_inv;

  logic [TAGW-1:0] frm_tag;
  msi_t            frm_state;
  msi_t            lk_state_e;
  logic            hit;
  logic            fsm_we;
  msi_t            fsm_state;
  logic            loc_we;

  // Block-offset bits of the snoop address play no part in the lookup.
  logic unused_snoop_offset;
  assign unused_snoop_offset = ^bus.ccsnoopaddr[BLKOFF-1:0];

  snoop_state_array #(.SETS(SETS)) u_array (
    .CLK       (CLK),
    .RST       (RST),
    .fsm_we    (fsm_we),
    .fsm_idx   (snp_idx),
    .fsm_state (fsm_state),
    .loc_we    (loc_we),
    .loc_idx   (loc_idx),
    .loc_tag   (loc_tag),
    .loc_state (loc_state),
    .snp_idx   (snp_idx),
    .snp_tag   (frm_tag),
    .snp_state (frm_state),
    .lk_idx    (lk_idx),
    .lk_tag    (lk_tag),
    .lk_state  (lk_state_e)
  );

  assign lk_state = lk_state_e;
  assign hit      = (frm_state != MSI_I) && (frm_tag == snp_tag);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= SN_IDLE;
    else     state <= state_next;
  end

  // Snoop context register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      snp_idx <= '0;
      snp_tag <= '0;
      snp_inv <= 1'b0;
    end else if (state == SN_IDLE && bus.ccwait) begin
      snp_idx <= bus.ccsnoopaddr[BLKOFF +: IDXW];
      snp_tag <= bus.ccsnoopaddr[ADDR_W-1 -: TAGW];
      snp_inv <= bus.ccinv;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      SN_IDLE:   if (bus.ccwait) state_next = SN_LOOKUP;
      SN_LOOKUP: begin
        if (hit && frm_state == MSI_M)             state_next = SN_WB0;
        else if (hit && frm_state == MSI_S && snp_inv) state_next = SN_UPDATE;
        else                                       state_next = SN_HOLD;
      end
      SN_WB0:    if (!bus.dwait) state_next = SN_WB1;
      SN_WB1:    if (!bus.dwait) state_next = SN_UPDATE;
      SN_UPDATE: state_next = SN_HOLD;
      // Stay here until the bus controller ends this snoop.
      SN_HOLD:   if (!bus.ccwait) state_next = SN_IDLE;
      default:   state_next = SN_IDLE;
    endcase
  end

  // Output and array-write decode.
  always_comb begin
    bus.ccwrite = 1'b0;
    bus.cctrans = 1'b0;
    bus.dWEN    = 1'b0;
    bus.daddr   = '0;
    bus.dstore  = '0;
    arr_ridx    = '0;
    arr_roff    = 1'b0;
    loc_busy    = (state != SN_IDLE);
    fsm_we      = 1'b0;
    fsm_state   = MSI_I;
    // Local write lands in IDLE, so a same-cycle snoop looks up the new frame.
    loc_we      = loc_set && (state == SN_IDLE);
    case (state)
      SN_LOOKUP: begin
        if (hit && frm_state == MSI_M) begin
          bus.ccwrite = 1'b1;
          bus.cctrans = 1'b1;
        end else if (hit && frm_state == MSI_S && snp_inv) begin
          bus.cctrans = 1'b1;
        end
      end
      SN_WB0: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {snp_tag, snp_idx, 3'b000};
        arr_ridx   = snp_idx;
        arr_roff   = 1'b0;
        bus.dstore = arr_rdata;
      end
      SN_WB1: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {snp_tag, snp_idx, 3'b100};
        arr_ridx   = snp_idx;
        arr_roff   = 1'b1;
        bus.dstore = arr_rdata;
      end
      SN_UPDATE: begin
        fsm_we    = 1'b1;
        fsm_state = snp_inv ? MSI_I : MSI_S;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Scoreboard bench for dcache_snoop_responder: stimulus pushes expected bus
// events, a negedge monitor pops and compares whatever the DUT presents.
module tb_dcache_snoop_responder;

  localparam int unsigned SETS = 16;
  localparam int unsigned IDXW = 4;
  localparam int unsigned TAGW = 25;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [IDXW-1:0] arr_ridx;
  logic            arr_roff;
  logic [31:0]     arr_rdata;
  logic            loc_set = 1'b0;
  logic [IDXW-1:0] loc_idx = '0;
  logic [TAGW-1:0] loc_tag = '0;
  logic [1:0]      loc_state = 2'b00;
  logic            loc_busy;
  logic [IDXW-1:0] lk_idx = '0;
  logic [TAGW-1:0] lk_tag;
  logic [1:0]      lk_state;

  logic [31:0] mem [SETS][2];

  dcache_snoop_responder_if bus_if ();

  dcache_snoop_responder #(.SETS(SETS)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus_if.slave),
    .arr_ridx  (arr_ridx),
    .arr_roff  (arr_roff),
    .arr_rdata (arr_rdata),
    .loc_set   (loc_set),
    .loc_idx   (loc_idx),
    .loc_tag   (loc_tag),
    .loc_state (loc_state),
    .loc_busy  (loc_busy),
    .lk_idx    (lk_idx),
    .lk_tag    (lk_tag),
    .lk_state  (lk_state)
  );

  always #5 CLK = ~CLK;

  assign arr_rdata = mem[arr_ridx][arr_roff];

  typedef struct packed {
    logic        is_word;
    logic        ccwrite;
    logic        cctrans;
    logic [31:0] daddr;
    logic [31:0] dstore;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  dwen_cycles = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every pulse and every dWEN cycle must match the queue head.
  always @(negedge CLK) begin
    ev_t e;
    if (!RST) begin
      if (bus_if.ccwrite || bus_if.cctrans) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pulse: got ccwrite=%b cctrans=%b expected none",
                   bus_if.ccwrite, bus_if.cctrans);
        end else begin
          e = exp_q.pop_front();
          check("pulse", {93'd0, 1'b0, bus_if.ccwrite, bus_if.cctrans},
                {93'd0, e.is_word, e.ccwrite, e.cctrans});
        end
      end
      if (bus_if.dWEN) begin
        dwen_cycles++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_dwen: got daddr=%h dstore=%h expected none",
                   bus_if.daddr, bus_if.dstore);
        end else begin
          e = exp_q[0];
          check("wb_word", {31'd0, 1'b1, bus_if.daddr, bus_if.dstore},
                {31'd0, e.is_word, e.daddr, e.dstore});
          if (!bus_if.dwait) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_pulse(input logic w, input logic t);
    exp_q.push_back('{is_word: 1'b0, ccwrite: w, cctrans: t, daddr: 32'd0, dstore: 32'd0});
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{is_word: 1'b1, ccwrite: 1'b0, cctrans: 1'b0, daddr: a, dstore: d});
  endtask

  task automatic do_loc_set(input logic [IDXW-1:0] i, input logic [TAGW-1:0] t, input logic [1:0] s);
    loc_set = 1'b1; loc_idx = i; loc_tag = t; loc_state = s;
    tick();
    loc_set = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [IDXW-1:0] i, input logic [1:0] s);
    lk_idx = i;
    #1;
    check(name, {94'd0, lk_state}, {94'd0, s});
  endtask

  // One snoop: ccwait held for 'hold' cycles; dwait high 'delay' cycles per
  // word; optional loc_set at cycle 'loc_cycle' (0 = same cycle ccwait rises).
  task automatic snoop(input logic [31:0] addr, input logic inv, input int delay,
                       input int hold, input int loc_cycle, input logic [IDXW-1:0] li,
                       input logic [TAGW-1:0] lt, input logic [1:0] ls);
    int wcnt = 0;
    bus_if.ccwait = 1'b1; bus_if.ccsnoopaddr = addr; bus_if.ccinv = inv;
    for (int c = 0; c < hold; c++) begin
      if (c == loc_cycle) begin
        if (c > 0) check("busy_in_snoop", {95'd0, loc_busy}, 96'd1);
        loc_set = 1'b1; loc_idx = li; loc_tag = lt; loc_state = ls;
      end
      tick();
      loc_set = 1'b0;
      if (bus_if.dWEN) begin
        if (wcnt < delay) begin bus_if.dwait = 1'b1; wcnt++; end
        else begin bus_if.dwait = 1'b0; wcnt = 0; end
      end else begin
        bus_if.dwait = 1'b0;
      end
    end
    bus_if.ccwait = 1'b0; bus_if.dwait = 1'b0; bus_if.ccinv = 1'b0;
    for (int c = 0; c < 50 && loc_busy; c++) tick();
    if (loc_busy) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got loc_busy=1 expected 0");
    end
    tick();
    check("queue_drained", 96'(exp_q.size()), 96'd0);
  endtask

  initial begin
    int base;
    for (int s = 0; s < int'(SETS); s++) begin
      mem[s][0] = 32'h0;
      mem[s][1] = 32'h0;
    end
    mem[5][0] = 32'hAAAA0000; mem[5][1] = 32'hBBBB1111;
    mem[3][0] = 32'h33330000; mem[3][1] = 32'h33331111;
    mem[2][0] = 32'h22220000; mem[2][1] = 32'h22221111;
    bus_if.ccwait = 1'b0; bus_if.ccinv = 1'b0; bus_if.ccsnoopaddr = 32'h0; bus_if.dwait = 1'b0;

    // 1: reset state
    tick(); tick();
    RST = 1'b0;
    check("rst_pulses", {94'd0, bus_if.ccwrite, bus_if.cctrans}, 96'd0);
    check("rst_dwen_busy", {94'd0, bus_if.dWEN, loc_busy}, 96'd0);
    check("rst_daddr_dstore", {32'd0, bus_if.daddr, bus_if.dstore}, 96'd0);
    check("rst_arr", {91'd0, arr_ridx, arr_roff}, 96'd0);
    for (int i = 0; i < int'(SETS); i++) check_frame("rst_frame_I", IDXW'(i), 2'b00);

    // 2: M hit read, no back-pressure -> S
    do_loc_set(4'd5, 25'h1234, 2'b10);
    push_pulse(1'b1, 1'b1);
    push_word(32'h00091A28, 32'hAAAA0000);
    push_word(32'h00091A2C, 32'hBBBB1111);
    base = dwen_cycles;
    snoop(32'h00091A28, 1'b0, 0, 6, -1, '0, '0, 2'b00);
    check("m_read_dwen_cycles", 96'(dwen_cycles - base), 96'd2);
    check_frame("m_read_to_S", 4'd5, 2'b01);
    lk_idx = 4'd5; #1;
    check("m_read_tag_kept", 96'(lk_tag), 96'h1234);

    // 3: M hit invalidate with dwait high 3 cycles per word -> I
    do_loc_set(4'd5, 25'h1234, 2'b10);
    push_pulse(1'b1, 1'b1);
    push_word(32'h00091A28, 32'hAAAA0000);
    push_word(32'h00091A2C, 32'hBBBB1111);
    base = dwen_cycles;
    snoop(32'h00091A2C, 1'b1, 3, 14, -1, '0, '0, 2'b00);
    check("m_inv_dwen_cycles", 96'(dwen_cycles - base), 96'd8);
    check_frame("m_inv_to_I", 4'd5, 2'b00);

    // 4: S hit invalidate -> cctrans only, frame I; S hit read -> nothing
    do_loc_set(4'd6, 25'h0ABC, 2'b01);
    push_pulse(1'b0, 1'b1);
    base = dwen_cycles;
    snoop(32'h00055E30, 1'b1, 0, 5, -1, '0, '0, 2'b00);
    check("s_inv_no_dwen", 96'(dwen_cycles - base), 96'd0);
    check_frame("s_inv_to_I", 4'd6, 2'b00);
    do_loc_set(4'd6, 25'h0ABC, 2'b01);
    snoop(32'h00055E30, 1'b0, 0, 5, -1, '0, '0, 2'b00);
    check_frame("s_read_stays_S", 4'd6, 2'b01);

    // 5: tag mismatch; then I frame with matching tag, loc_set during HOLD
    snoop(32'h00055EB0, 1'b1, 0, 5, -1, '0, '0, 2'b00);
    check_frame("miss_keeps_S", 4'd6, 2'b01);
    snoop(32'h00000048, 1'b1, 0, 8, 4, 4'd7, 25'h0042, 2'b10);
    check_frame("hold_ignores_loc", 4'd7, 2'b00);

    // illegal local state stored as I
    do_loc_set(4'd8, 25'h0055, 2'b11);
    check_frame("illegal_state_I", 4'd8, 2'b00);

    // 6a: local write to M in the same cycle the snoop arrives
    push_pulse(1'b1, 1'b1);
    push_word(32'h00003B98, 32'h33330000);
    push_word(32'h00003B9C, 32'h33331111);
    snoop(32'h00003B98, 1'b0, 0, 6, 0, 4'd3, 25'h0077, 2'b10);
    check_frame("same_cycle_to_S", 4'd3, 2'b01);

    // 6b: RST while in WB1
    do_loc_set(4'd2, 25'h0010, 2'b10);
    push_pulse(1'b1, 1'b1);
    push_word(32'h00000810, 32'h22220000);
    push_word(32'h00000814, 32'h22221111);
    bus_if.ccwait = 1'b1; bus_if.ccsnoopaddr = 32'h00000810; bus_if.ccinv = 1'b0;
    tick();                       // LOOKUP
    tick();                       // WB0, accepted this cycle
    tick();                       // WB1
    check("wb1_dwen", {95'd0, bus_if.dWEN}, 96'd1);
    bus_if.dwait = 1'b1;
    RST = 1'b1;
    bus_if.ccwait = 1'b0;
    tick();
    check("rst_abort_dwen", {94'd0, bus_if.dWEN, loc_busy}, 96'd0);
    check("rst_abort_daddr", {64'd0, bus_if.daddr}, 96'd0);
    RST = 1'b0;
    bus_if.dwait = 1'b0;
    check("abort_left_word1", 96'(exp_q.size()), 96'd1);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    for (int i = 0; i < int'(SETS); i++) check_frame("abort_frame_I", IDXW'(i), 2'b00);
    tick(); tick();
    check("final_queue_empty", 96'(exp_q.size()), 96'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_snoop_responder.md
Name: dcache_snoop_responder

Overview:
Cache-side end of the dual-core MSI snoop protocol. Lives inside each L1 dcache and holds the per-frame tag and MSI state. It answers bus-controller snoops (ccwait/ccsnoopaddr/ccinv) by flagging a Modified hit (ccwrite/cctrans), writing the dirty 2-word block back over the dREN/dWEN/dwait port, and downgrading or invalidating the frame. It also applies fill and write state updates from the local cache controller.

Parameters:
SETS, 16, number of direct-mapped frames; power of 2, at least 2. IDXW = log2(SETS).
TAGW, 32-3-IDXW, tag width.

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-high reset
ccwait  in  1  snoop active; held high by the bus controller for the whole snoop
ccinv  in  1  snoop carries an invalidate (BusRdX); sampled with ccwait
ccsnoopaddr  in  32  snooped word address
ccwrite  out  1  snooped frame is M; this cache supplies the data
cctrans  out  1  this cache's frame is changing state
dWEN  out  1  writeback strobe to the bus
daddr  out  32  writeback address
dstore  out  32  writeback data
dwait  in  1  bus not ready; a word is accepted in a cycle where dWEN=1 and dwait=0
arr_ridx  out  IDXW  data array read index
arr_roff  out  1  data array word offset
arr_rdata  in  32  data array word, combinational from arr_ridx/arr_roff
loc_set  in  1  local state write request
loc_idx  in  IDXW  frame to write
loc_tag  in  TAGW  new tag
loc_state  in  2  new MSI state
loc_busy  out  1  high whenever the FSM is not in IDLE; loc_set is ignored while high
lk_idx  in  IDXW  local lookup index
lk_tag  out  TAGW  combinational tag read
lk_state  out  2  combinational state read

Behaviour:
- Address split: tag = [31:IDXW+3], idx = [IDXW+2:3], word offset = [2], byte = [1:0] (ignored).
- Reset: all frames are set to I with tag 0. FSM goes to IDLE. ccwrite, cctrans, dWEN, daddr, dstore, arr_ridx, arr_roff and loc_busy are all 0.
- RST during any state aborts immediately: dWEN drops in the next cycle and no state update is applied.
- States: IDLE, LOOKUP, WB0, WB1, UPDATE, HOLD.
- IDLE:
  - If loc_set=1, write tag and state at loc_idx.
  - If ccwait=1, register snoop idx/tag/ccinv and go to LOOKUP.
  - If loc_set and ccwait arrive in the same cycle, the local write lands first, and LOOKUP sees the updated frame.
- LOOKUP (1 cycle). hit = frame state != I and stored tag == snoop tag.
  - hit and M: ccwrite=1, cctrans=1; go to WB0.
  - hit and S with ccinv=1: cctrans=1; go to UPDATE.
  - Otherwise: all outputs 0; go to HOLD.
- WB0: dWEN=1, daddr={tag,idx,3'b000}, arr_ridx=idx, arr_roff=0, dstore=arr_rdata. Hold until dwait=0, then go to WB1.
- WB1: same as WB0 but arr_roff=1 and daddr={tag,idx,3'b100}. Hold until dwait=0, then go to UPDATE.
- ccwait dropping during WB0/WB1 is ignored; the writeback always completes.
- UPDATE (1 cycle): new state is I if ccinv, else S. Tag is unchanged. Go to HOLD.
- HOLD: wait for ccwait=0, then go to IDLE. This prevents a second response to the same snoop.
- ccwrite and cctrans are 1-cycle pulses in LOOKUP only. cctrans is 0 on misses and on S-hit reads.
- dWEN is asserted only in WB0/WB1.
- lk_tag and lk_state are always live, including during a snoop.
- Latency: a snoop miss reaches HOLD 2 cycles after ccwait rises. An M hit with dwait=0 throughout reaches UPDATE 4 cycles after ccwait rises.
- loc_state=2'b11 is illegal; the array stores it as I.

Decomposition:
- Shared package (cpu_types_pkg or a new coherence_pkg):
  - msi_t enum: I=2'b00, S=2'b01, M=2'b10.
  - snoop_state_t enum for the six FSM states.
  - Constants: BLKOFF=3 and the address field positions.
- One sub-module: snoop_state_array.
  - Holds the SETS-entry tag+state storage.
  - One synchronous write port with FSM write priority over local writes.
  - Two combinational read ports (snoop and local).
  - Synchronous RST clears it to I.

Test Plan:
1. Reset, then lk_idx 0..15 -> every lk_state=I; all outputs 0; loc_busy=0.
2. loc_set idx 5, tag 0x1234, state M; data words 0xAAAA0000/0xBBBB1111; ccwait with ccsnoopaddr matching idx 5 and tag 0x1234, ccinv=0, dwait=0 -> one-cycle ccwrite=cctrans=1, then dWEN for 2 cycles with daddr ...28/...2C and dstore AAAA0000 then BBBB1111. Frame 5 ends in S.
3. Same setup with ccinv=1 and dwait held high 3 cycles per word -> each word stays on the bus until accepted. Frame 5 ends in I.
4. Frame in S, snoop with ccinv=1 -> cctrans pulse, no ccwrite, no dWEN, frame goes to I. Frame in S, snoop with ccinv=0 -> no pulses, frame stays S.
5. Snoop to a tag mismatch or an I frame -> no ccwrite/cctrans/dWEN. HOLD persists until ccwait falls. loc_set applied during HOLD is ignored.
6. loc_set (idx 3 to M) in the same cycle ccwait rises for idx 3 -> the snoop sees M and writes back. In a separate run, RST during WB1 -> dWEN=0 next cycle and all frames are I.
